// File: rtl/input_feed_sched_pkg.sv
// Shared definitions for the input activation feed sequencer: FSM state
// encodings and the drain settle length.
package input_feed_pkg;

   typedef logic [2:0] state_t;

   localparam state_t IDLE    = 3'd0;
   localparam state_t CLEAR   = 3'd1;
   localparam state_t FILL    = 3'd2;
   localparam state_t FLUSH   = 3'd3;
   localparam state_t FEED    = 3'd4;
   localparam state_t DRAIN   = 3'd5;
   localparam state_t DONE_ST = 3'd6;

   // Consecutive quiet cycles (FIFO empty, no output valid) that end a drain.
   localparam int DRAIN_SETTLE = 2;

endpackage

// File: rtl/input_feed_sched_if.sv
// Signal bundle between the feed sequencer (master) and its environment:
// layer config, activation memory read port, activation controller FIFO port.
interface input_feed_sched_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 16
) ();

   // Handshake: no valid/ready back-pressure. MEM_RD_DATA is valid exactly one
   // cycle after MEM_RD_EN; FIFO_WR_CMD pushes FIFO_WR_DATA in the same cycle and
   // FIFO_FULL is advisory only (a write while full is flagged on ERR).
   logic                  CFG_START;
   logic [ADDR_WIDTH-1:0] CFG_BASE_ADDR;
   logic [LEN_WIDTH-1:0]  CFG_NUM_WORDS;
   logic                  MEM_RD_EN;
   logic [ADDR_WIDTH-1:0] MEM_RD_ADDR;
   logic [DATA_WIDTH-1:0] MEM_RD_DATA;
   logic                  CLEAR_FIFO;
   logic                  START_FEED;
   logic                  FIFO_WR_CMD;
   logic [DATA_WIDTH-1:0] FIFO_WR_DATA;
   logic                  FIFO_FULL;
   logic                  FIFO_EMPTY;
   logic                  DATA_VALID;
   logic                  BUSY;
   logic                  DONE;
   logic                  ERR;
   logic [31:0]           PERF_CYCLES;
   logic [2:0]            DBG_STATE;

   modport master (
      input  CFG_START, CFG_BASE_ADDR, CFG_NUM_WORDS, MEM_RD_DATA,
             FIFO_FULL, FIFO_EMPTY, DATA_VALID,
      output MEM_RD_EN, MEM_RD_ADDR, CLEAR_FIFO, START_FEED, FIFO_WR_CMD,
             FIFO_WR_DATA, BUSY, DONE, ERR, PERF_CYCLES, DBG_STATE
   );

   modport slave (
      output CFG_START, CFG_BASE_ADDR, CFG_NUM_WORDS, MEM_RD_DATA,
             FIFO_FULL, FIFO_EMPTY, DATA_VALID,
      input  MEM_RD_EN, MEM_RD_ADDR, CLEAR_FIFO, START_FEED, FIFO_WR_CMD,
             FIFO_WR_DATA, BUSY, DONE, ERR, PERF_CYCLES, DBG_STATE
   );

endinterface

// File: rtl/input_feed_sched.sv
// Loads activations from memory into the activation controller FIFO in chunks
// of at most FIFO_DEPTH words, feeding and draining each. Busy-cycle counter is
// built only when INPUT_FEED_SCHED_PERF_EN is defined.
module input_feed_sched
   import input_feed_pkg::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 64,
   parameter int LEN_WIDTH  = 16
) (
   input logic               CLK,
   input logic               RESETN,
   input_feed_sched_if.master bus
);

   localparam logic [LEN_WIDTH-1:0] DEPTH_L     = LEN_WIDTH'(FIFO_DEPTH);
   localparam logic [1:0]           SETTLE_LAST = 2'(DRAIN_SETTLE - 1);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
   logic [LEN_WIDTH-1:0]  chunk_q, chunk_d;
   logic [LEN_WIDTH-1:0]  issued_q, issued_d;
   logic [1:0]            settle_q, settle_d;
   logic                  err_q, err_d;
   logic                  start_prev_q;
   logic                  wr_cmd_q;

   logic                  start_rise;
   logic                  drained;
   logic [LEN_WIDTH-1:0]  next_chunk;
   logic [LEN_WIDTH-1:0]  issued_inc;
   logic [DATA_WIDTH-1:0] wr_data;

   assign start_rise = bus.CFG_START & ~start_prev_q;
   assign drained    = bus.FIFO_EMPTY & ~bus.DATA_VALID;
   assign next_chunk = (remaining_q > DEPTH_L) ? DEPTH_L : remaining_q;
   assign issued_inc = issued_q + LEN_WIDTH'(1);

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      chunk_d     = chunk_q;
      issued_d    = issued_q;
      settle_d    = settle_q;
      err_d       = err_q;
      case (state_q)
         IDLE: if (start_rise) begin
            addr_d      = bus.CFG_BASE_ADDR;
            remaining_d = bus.CFG_NUM_WORDS;
            err_d       = 1'b0;
            state_d     = CLEAR;
         end
         CLEAR: begin
            if (remaining_q == '0) begin
               state_d = DONE_ST;
            end else begin
               state_d  = FILL;
               chunk_d  = next_chunk;
               issued_d = '0;
            end
         end
         FILL: begin
            addr_d   = addr_q + ADDR_WIDTH'(1);
            issued_d = issued_inc;
            if (issued_inc == chunk_q) state_d = FLUSH;
         end
         FLUSH: begin
            remaining_d = remaining_q - chunk_q;
            state_d     = FEED;
         end
         FEED: begin
            settle_d = '0;
            state_d  = DRAIN;
         end
         DRAIN: begin
            if (!drained) begin
               settle_d = '0;
            end else if (settle_q != SETTLE_LAST) begin
               settle_d = settle_q + 2'd1;
            end else if (remaining_q != '0) begin
               state_d  = FILL;
               chunk_d  = next_chunk;
               issued_d = '0;
            end else begin
               state_d = DONE_ST;
            end
         end
         DONE_ST: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Overflow is only recorded; the write itself still goes out.
      if (wr_cmd_q && bus.FIFO_FULL) err_d = 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         remaining_q  <= '0;
         chunk_q      <= '0;
         issued_q     <= '0;
         settle_q     <= '0;
         err_q        <= 1'b0;
         start_prev_q <= 1'b0;
         wr_cmd_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         remaining_q  <= remaining_d;
         chunk_q      <= chunk_d;
         issued_q     <= issued_d;
         settle_q     <= settle_d;
         err_q        <= err_d;
         start_prev_q <= bus.CFG_START;
         wr_cmd_q     <= (state_q == FILL);
      end
   end

   // Write data is gated so the FIFO port reads all-zero whenever no push is active.
   assign wr_data          = wr_cmd_q ? bus.MEM_RD_DATA : '0;
   assign bus.FIFO_WR_DATA = wr_data;
   assign bus.FIFO_WR_CMD  = wr_cmd_q;
   assign bus.MEM_RD_EN    = (state_q == FILL);
   assign bus.MEM_RD_ADDR  = (state_q == FILL) ? addr_q : '0;
   assign bus.CLEAR_FIFO   = (state_q == CLEAR);
   assign bus.START_FEED   = (state_q == FEED);
   assign bus.BUSY         = (state_q != IDLE);
   assign bus.DONE         = (state_q == DONE_ST);
   assign bus.ERR          = err_q;
   assign bus.DBG_STATE    = state_q;

`ifdef INPUT_FEED_SCHED_PERF_EN
   logic [31:0] perf_q;

   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         perf_q <= '0;
      end else if (state_q == IDLE && start_rise) begin
         perf_q <= '0;
      end else if (state_q != IDLE && perf_q != 32'hFFFF_FFFF) begin
         perf_q <= perf_q + 32'd1;
      end
   end

   assign bus.PERF_CYCLES = perf_q;
`else
   assign bus.PERF_CYCLES = '0;
`endif

endmodule

// File: tb/tb_input_feed_sched.sv
// Directed bench for input_feed_sched with a one-cycle-latency memory model and
// a draining activation FIFO model; honours INPUT_FEED_SCHED_PERF_EN.
module tb_input_feed_sched;
   import input_feed_pkg::*;

   // ---------------- clock / reset ----------------
   logic CLK = 1'b0;
   logic RESETN = 1'b0;
   always #5 CLK = ~CLK;

   input_feed_sched_if bus ();

   input_feed_sched dut (
      .CLK    (CLK),
      .RESETN (RESETN),
      .bus    (bus.master)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- memory model ----------------
   function automatic logic [31:0] mem_word(input logic [15:0] a);
      return {a ^ 16'hC3A5, a};
   endfunction

   logic [31:0] mem_data_q = '0;
   always @(posedge CLK) if (bus.MEM_RD_EN) mem_data_q <= mem_word(bus.MEM_RD_ADDR);
   assign bus.MEM_RD_DATA = mem_data_q;

   // ---------------- activation FIFO model ----------------
   int   fifo_cnt   = 0;
   logic feeding    = 1'b0;
   logic dv_q       = 1'b0;
   logic force_full = 1'b0;
   logic pop;

   assign pop = feeding && (fifo_cnt > 0);
   always @(posedge CLK) begin
      if (!RESETN || bus.CLEAR_FIFO) begin
         fifo_cnt <= 0;
         feeding  <= 1'b0;
         dv_q     <= 1'b0;
      end else begin
         fifo_cnt <= fifo_cnt + (bus.FIFO_WR_CMD ? 1 : 0) - (pop ? 1 : 0);
         dv_q     <= pop;
         if (bus.START_FEED) feeding <= 1'b1;
         else if (fifo_cnt == 0) feeding <= 1'b0;
      end
   end
   assign bus.FIFO_EMPTY = (fifo_cnt == 0);
   assign bus.FIFO_FULL  = (fifo_cnt >= 64) || force_full;
   assign bus.DATA_VALID = dv_q;

   // ---------------- monitor / scoreboard ----------------
   int          rd_cnt, wr_cnt, clr_cnt, feed_cnt, done_cnt, busy_cnt, wr_since_feed, addr_err;
   logic [15:0] exp_addr, last_addr;
   int          chunk_log[$];
   logic [31:0] exp_q[$];

   always @(negedge CLK) begin
      if (bus.MEM_RD_EN) begin
         if (bus.MEM_RD_ADDR !== exp_addr) addr_err++;
         exp_addr  = bus.MEM_RD_ADDR + 16'd1;
         last_addr = bus.MEM_RD_ADDR;
         exp_q.push_back(mem_word(bus.MEM_RD_ADDR));
         rd_cnt++;
      end
      if (bus.FIFO_WR_CMD) begin
         wr_cnt++;
         wr_since_feed++;
         if (exp_q.size() == 0) check("wr_unexpected", 64'd1, 64'd0);
         else check("wr_data", bus.FIFO_WR_DATA, exp_q.pop_front());
      end
      if (bus.CLEAR_FIFO) clr_cnt++;
      if (bus.START_FEED) begin
         feed_cnt++;
         chunk_log.push_back(wr_since_feed);
         wr_since_feed = 0;
      end
      if (bus.DONE) done_cnt++;
      if (bus.BUSY) busy_cnt++;
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(negedge CLK);
   endtask

   task automatic clear_stats(input logic [15:0] base);
      rd_cnt = 0; wr_cnt = 0; clr_cnt = 0; feed_cnt = 0; done_cnt = 0;
      busy_cnt = 0; wr_since_feed = 0; addr_err = 0;
      exp_addr = base; last_addr = '0;
      exp_q.delete();
      chunk_log.delete();
   endtask

   // Leaves the bench on the CLEAR-cycle negedge with CFG_START released.
   task automatic start(input logic [15:0] base, input logic [15:0] n);
      bus.CFG_BASE_ADDR = base;
      bus.CFG_NUM_WORDS = n;
      bus.CFG_START = 1'b1;
      tick();
      bus.CFG_START = 1'b0;
   endtask

   task automatic wait_done();
      int cyc = 0;
      while (!bus.DONE && cyc < 3000) begin
         tick();
         cyc++;
      end
      check("done_seen", bus.DONE, 1'b1);
      check("busy_at_done", bus.BUSY, 1'b1);
      tick();
      check("busy_after_done", bus.BUSY, 1'b0);
      check("done_is_pulse", bus.DONE, 1'b0);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"}, bus.BUSY, 1'b0);
      check({tag, "_done"}, bus.DONE, 1'b0);
      check({tag, "_err"}, bus.ERR, 1'b0);
      check({tag, "_clear"}, bus.CLEAR_FIFO, 1'b0);
      check({tag, "_feed"}, bus.START_FEED, 1'b0);
      check({tag, "_rd_en"}, bus.MEM_RD_EN, 1'b0);
      check({tag, "_rd_addr"}, bus.MEM_RD_ADDR, 16'h0);
      check({tag, "_wr_cmd"}, bus.FIFO_WR_CMD, 1'b0);
      check({tag, "_wr_data"}, bus.FIFO_WR_DATA, 32'h0);
      check({tag, "_perf"}, bus.PERF_CYCLES, 32'h0);
      check({tag, "_state"}, bus.DBG_STATE, IDLE);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed sequence ----------------
   initial begin
      logic [31:0] exp_perf;
      int          busy_snap;
      int          cyc;

      bus.CFG_START = 1'b0;
      bus.CFG_BASE_ADDR = '0;
      bus.CFG_NUM_WORDS = '0;
      clear_stats(16'h0);
      RESETN = 1'b0;
      repeat (3) tick();
      check_idle_outputs("reset");
      RESETN = 1'b1;
      tick();

      // 5 words from 0x0010: single chunk
      clear_stats(16'h0010);
      start(16'h0010, 16'd5);
      check("a_clear", bus.CLEAR_FIFO, 1'b1);
      check("a_busy", bus.BUSY, 1'b1);
      tick();
      check("a_first_rd_en", bus.MEM_RD_EN, 1'b1);
      check("a_first_addr", bus.MEM_RD_ADDR, 16'h0010);
      wait_done();
      repeat (3) tick();
      check("a_rd_cnt", rd_cnt, 5);
      check("a_wr_cnt", wr_cnt, 5);
      check("a_clr_cnt", clr_cnt, 1);
      check("a_feed_cnt", feed_cnt, 1);
      check("a_done_cnt", done_cnt, 1);
      check("a_addr_seq", addr_err, 0);
      check("a_last_addr", last_addr, 16'h0014);
      check("a_exp_q_empty", exp_q.size(), 0);
      check("a_err", bus.ERR, 1'b0);
`ifdef INPUT_FEED_SCHED_PERF_EN
      exp_perf = 32'(busy_cnt);
`else
      exp_perf = 32'h0;
`endif
      check("a_perf_hold", bus.PERF_CYCLES, exp_perf);

      // 130 words from 0xFFC0: chunks 64/64/2, address wraps to 0x0041
      clear_stats(16'hFFC0);
      start(16'hFFC0, 16'd130);
      wait_done();
      repeat (2) tick();
      check("b_rd_cnt", rd_cnt, 130);
      check("b_wr_cnt", wr_cnt, 130);
      check("b_clr_cnt", clr_cnt, 1);
      check("b_feed_cnt", feed_cnt, 3);
      check("b_addr_seq", addr_err, 0);
      check("b_last_addr", last_addr, 16'h0041);
      check("b_err", bus.ERR, 1'b0);
      check("b_chunks", chunk_log.size(), 3);
      if (chunk_log.size() == 3) begin
         check("b_chunk0", chunk_log[0], 64);
         check("b_chunk1", chunk_log[1], 64);
         check("b_chunk2", chunk_log[2], 2);
      end

      // zero words: CLEAR then DONE, no reads
      clear_stats(16'h0);
      start(16'h0033, 16'd0);
      check("c_clear", bus.CLEAR_FIFO, 1'b1);
      tick();
      check("c_done", bus.DONE, 1'b1);
      tick();
      check("c_idle", bus.BUSY, 1'b0);
      tick();
      check("c_rd_cnt", rd_cnt, 0);
      check("c_clr_cnt", clr_cnt, 1);

      // re-start edge during FILL is ignored; CFG_START held high after DONE
      clear_stats(16'h0100);
      bus.CFG_BASE_ADDR = 16'h0100;
      bus.CFG_NUM_WORDS = 16'd5;
      bus.CFG_START = 1'b1;
      tick();
      bus.CFG_START = 1'b0;
      tick();
      bus.CFG_BASE_ADDR = 16'h0200;
      bus.CFG_NUM_WORDS = 16'd9;
      bus.CFG_START = 1'b1;
      tick();
      check("d_state_fill", bus.DBG_STATE, FILL);
      wait_done();
      busy_snap = busy_cnt;
      repeat (10) tick();
      check("d_no_restart", busy_cnt, busy_snap);
      check("d_rd_cnt", rd_cnt, 5);
      check("d_last_addr", last_addr, 16'h0104);
      check("d_done_cnt", done_cnt, 1);
      bus.CFG_START = 1'b0;
      tick();

      // reset during FILL of chunk 2 abandons the transfer
      clear_stats(16'h0300);
      start(16'h0300, 16'd130);
      cyc = 0;
      while (!(feed_cnt == 1 && bus.MEM_RD_EN) && cyc < 2000) begin
         tick();
         cyc++;
      end
      check("e_in_chunk2_fill", bus.DBG_STATE, FILL);
      tick();
      RESETN = 1'b0;
      tick();
      check_idle_outputs("e_reset");
      tick();
      RESETN = 1'b1;
      tick();
      check("e_no_done", done_cnt, 0);
      clear_stats(16'h0400);
      start(16'h0400, 16'd5);
      wait_done();
      repeat (2) tick();
      check("e_rerun_rd", rd_cnt, 5);
      check("e_rerun_wr", wr_cnt, 5);
      check("e_rerun_done", done_cnt, 1);
      check("e_rerun_q", exp_q.size(), 0);

      // overflow: write while FIFO_FULL sets sticky ERR
      clear_stats(16'h0500);
      start(16'h0500, 16'd5);
      cyc = 0;
      while (!bus.FIFO_WR_CMD && cyc < 50) begin
         tick();
         cyc++;
      end
      check("f_wr_seen", bus.FIFO_WR_CMD, 1'b1);
      force_full = 1'b1;
      tick();
      force_full = 1'b0;
      check("f_err_set", bus.ERR, 1'b1);
      wait_done();
      check("f_err_held", bus.ERR, 1'b1);
      check("f_wr_cnt", wr_cnt, 5);
      tick();
      clear_stats(16'h0600);
      start(16'h0600, 16'd5);
      check("f_err_cleared", bus.ERR, 1'b0);
      wait_done();
      check("f_err_clean", bus.ERR, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/input_feed_sched.md
Name: input_feed_sched

Overview:
- Sequencer that loads input activations from a word-addressed on-chip activation memory into the input activation controller's FIFO, then triggers and supervises feeding.
- Splits a transfer of CFG_NUM_WORDS words into chunks of at most FIFO_DEPTH words. Each chunk is a fill, then a START_FEED pulse, then a wait for drain.
- Sits between the layer control registers and the input activation controller; it owns that controller's CLEAR_FIFO, START_FEED and FIFO write port.

Parameters:
- ADDR_WIDTH, 16, activation memory word-address width
- DATA_WIDTH, 32, memory word and FIFO word width
- FIFO_DEPTH, 64, FIFO depth in words; maximum chunk length
- LEN_WIDTH, 16, width of the word-count configuration

Ports:
- CLK  in  1  clock
- RESETN  in  1  reset (see Behaviour)
- CFG_START  in  1  level; a rising edge starts a transfer
- CFG_BASE_ADDR  in  ADDR_WIDTH  first word address, sampled on start
- CFG_NUM_WORDS  in  LEN_WIDTH  total words, sampled on start
- MEM_RD_EN  out  1  memory read strobe
- MEM_RD_ADDR  out  ADDR_WIDTH  memory read address
- MEM_RD_DATA  in  DATA_WIDTH  read data, valid exactly 1 cycle after MEM_RD_EN
- CLEAR_FIFO  out  1  to the activation controller
- START_FEED  out  1  to the activation controller
- FIFO_WR_CMD  out  1  FIFO push
- FIFO_WR_DATA  out  DATA_WIDTH  FIFO push data
- FIFO_FULL  in  1  FIFO full flag
- FIFO_EMPTY  in  1  FIFO empty flag
- DATA_VALID  in  1  activation controller output-valid flag
- BUSY  out  1  high whenever state is not IDLE
- DONE  out  1  one-cycle pulse at transfer end
- ERR  out  1  sticky overflow flag
- PERF_CYCLES  out  32  busy-cycle count (Optional Feature)

Behaviour:
- Reset: RESETN is synchronous, active-low, on CLK. While it is low, state goes to IDLE and every output is 0, including ERR, PERF_CYCLES and CFG_START edge history. Reset mid-transfer abandons the transfer; no DONE is generated.
- Start: a CFG_START rising edge (registered prev = 0, current = 1) starts a transfer only in IDLE. Edges in any other state are ignored.
- On start: latch base address into addr and CFG_NUM_WORDS into remaining. Clear ERR and go to CLEAR.
- CLEAR (1 cycle): CLEAR_FIFO = 1. Next state: DONE_ST if remaining == 0, else FILL. CLEAR_FIFO is low in every other state, so the controller always sees a fresh edge.
- FILL entry: chunk = min(remaining, FIFO_DEPTH); issued = 0.
- FILL each cycle: MEM_RD_EN = 1, MEM_RD_ADDR = addr, addr += 1 (wraps modulo 2^ADDR_WIDTH), issued += 1.
- FILL exit: when issued reaches chunk, go to FLUSH.
- Write pipeline: a registered copy of MEM_RD_EN drives FIFO_WR_CMD. FIFO_WR_DATA = MEM_RD_DATA. This gives 1-cycle read-to-write latency and back-to-back throughput.
- FLUSH (1 cycle): no read; the last write completes; remaining -= chunk.
- FEED (1 cycle): START_FEED = 1, low in every other state. FIFO_EMPTY is guaranteed 0 here.
- DRAIN: wait until FIFO_EMPTY = 1 and DATA_VALID = 0 for 2 consecutive cycles. Then go to FILL if remaining > 0, else DONE_ST. No CLEAR between chunks.
- DONE_ST (1 cycle): DONE = 1, then IDLE.
- Overflow: FIFO_FULL = 1 in a cycle where FIFO_WR_CMD = 1 sets ERR (sticky until next start). The write is still issued and sequencing continues.
- Arithmetic: remaining and issued are LEN_WIDTH wide. Chunk-length compare is unsigned.

Optional Feature:
- Macro: INPUT_FEED_SCHED_PERF_EN
- Defined: PERF_CYCLES clears on start and increments every cycle BUSY = 1. It saturates at 0xFFFFFFFF and holds after DONE until the next start.
- Undefined: PERF_CYCLES is tied to 0 and no counter logic is built.

Decomposition:
- Shared package input_feed_pkg:
  - state enum IDLE, CLEAR, FILL, FLUSH, FEED, DRAIN, DONE_ST
  - constant DRAIN_SETTLE = 2
- No sub-module required; the perf counter stays inline.

Test Plan:
- NUM_WORDS = 5, base 0x0010 -> one CLEAR_FIFO pulse. Reads at 0x0010..0x0014 on consecutive cycles, 5 FIFO writes with matching data, one START_FEED, DONE after drain, BUSY drops the same cycle DONE falls.
- NUM_WORDS = 130 -> chunks of 64, 64 and 2 writes, 3 START_FEED pulses each after a drain, a single CLEAR_FIFO, last address base + 129.
- NUM_WORDS = 0 -> CLEAR_FIFO pulse, no MEM_RD_EN, DONE 2 cycles after the start edge.
- Second CFG_START edge during FILL -> ignored, transfer finishes unchanged; CFG_START held high after DONE -> no restart until a new rising edge.
- RESETN low during FILL of chunk 2 -> all outputs 0 next cycle, state IDLE, no DONE; a new start runs normally.
- Force FIFO_FULL = 1 during a write -> ERR = 1 and held through DONE; cleared on next start. With PERF_EN, NUM_WORDS = 5 and a 10-cycle drain -> PERF_CYCLES equals the BUSY cycle count.
